// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for the ripple-carry adder.
// The master drives the operands and the slave returns the registered result.
interface ripple_carry_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, c_in,
        input  out_valid, out, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, c_in,
        output out_valid, out, c_out, overflow
    );
endinterface

// File: rtl/ripple_carry_adder.sv
// Reference low-area adder: a chain of WIDTH full-adder stages.
// The sum, carry-out and signed overflow are registered once, along with a valid strobe.
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    ripple_carry_adder_if.slave bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] out_q, out_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    assign carry[0] = bus.c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = bus.a[i] ^ bus.b[i] ^ carry[i];
        assign carry[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & carry[i]) | (bus.b[i] & carry[i]);
    end

    // Result registers hold during idle cycles so X operands never reach the outputs.
    always_comb begin
        out_d   = out_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            out_d   = sum;
            c_out_d = carry[WIDTH];
            ovf_d   = carry[WIDTH-1] ^ carry[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = ovf_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Bench for ripple_carry_adder: 16-bit and 8-bit instances share one stimulus stream,
// and each has its own queue of expected results checked one edge later.
module tb_ripple_carry_adder;

    typedef struct packed {
        logic        vld;
        logic        c;
        logic        ov;
        logic [15:0] o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    exp_t q16[$];
    exp_t q8[$];
    exp_t last16 = '0;
    exp_t last8  = '0;

    always #5 clk = ~clk;

    ripple_carry_adder_if #(.WIDTH(16)) bus16 ();
    ripple_carry_adder_if #(.WIDTH(8))  bus8 ();

    ripple_carry_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    ripple_carry_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    function automatic exp_t calc(input int unsigned w, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin);
        logic [16:0] mask;
        logic [16:0] s;
        exp_t        e;
        mask = (17'd1 << w) - 17'd1;
        s    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'd0, cin};
        e.vld = 1'b1;
        e.o   = s[15:0] & mask[15:0];
        e.c   = s[w];
        e.ov  = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return e;
    endfunction

    task automatic check(input string tag, input exp_t obs, input exp_t exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed vld=%b c_out=%b ovf=%b out=%h, expected vld=%b c_out=%b ovf=%b out=%h",
                   tag, obs.vld, obs.c, obs.ov, obs.o, exp.vld, exp.c, exp.ov, exp.o);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic v, input logic [15:0] a,
                        input logic [15:0] b, input logic cin);
        exp_t e16;
        exp_t e8;
        exp_t o16;
        exp_t o8;
        rst_n          = rst;
        bus16.in_valid = v;
        bus16.a        = a;
        bus16.b        = b;
        bus16.c_in     = cin;
        bus8.in_valid  = v;
        bus8.a         = a[7:0];
        bus8.b         = b[7:0];
        bus8.c_in      = cin;
        if (!rst) begin
            last16 = '0;
            last8  = '0;
            e16    = '0;
            e8     = '0;
        end else if (v) begin
            e16    = calc(16, a, b, cin);
            e8     = calc(8, a, b, cin);
            last16 = e16;
            last8  = e8;
        end else begin
            e16     = last16;
            e8      = last8;
            e16.vld = 1'b0;
            e8.vld  = 1'b0;
        end
        q16.push_back(e16);
        q8.push_back(e8);
        @(posedge clk);
        #1;
        o16 = {bus16.out_valid, bus16.c_out, bus16.overflow, bus16.out};
        o8  = {bus8.out_valid, bus8.c_out, bus8.overflow, 8'h00, bus8.out};
        check({tag, "_w16"}, o16, q16.pop_front());
        check({tag, "_w8"}, o8, q8.pop_front());
    endtask

    initial begin
        exp_t hard;
        rst_n          = 1'b0;
        bus16.in_valid = 1'b0;
        bus16.a        = '0;
        bus16.b        = '0;
        bus16.c_in     = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.c_in      = 1'b0;

        for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);

        step("1+1",      1'b1, 1'b1, 16'd1,   16'd1,    1'b0);
        step("1+10",     1'b1, 1'b1, 16'd1,   16'd10,   1'b0);
        step("15+31",    1'b1, 1'b1, 16'd15,  16'd31,   1'b0);
        step("128+1478", 1'b1, 1'b1, 16'd128, 16'd1478, 1'b0);
        hard = {1'b1, 1'b0, 1'b0, 16'd1606};
        check("const_1606", {bus16.out_valid, bus16.c_out, bus16.overflow, bus16.out}, hard);
        step("94+333",   1'b1, 1'b1, 16'd94,  16'd333,  1'b0);

        step("wrap_b1",   1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        hard = {1'b1, 1'b1, 1'b0, 16'h0000};
        check("const_wrap", {bus16.out_valid, bus16.c_out, bus16.overflow, bus16.out}, hard);
        step("wrap_cin",  1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        step("ovf_pos",   1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
        hard = {1'b1, 1'b0, 1'b1, 16'h8000};
        check("const_ovf_pos", {bus16.out_valid, bus16.c_out, bus16.overflow, bus16.out}, hard);
        step("ovf_neg",   1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0);
        hard = {1'b1, 1'b1, 1'b1, 16'h0000};
        check("const_ovf_neg", {bus16.out_valid, bus16.c_out, bus16.overflow, bus16.out}, hard);

        step("gate_5+7",  1'b1, 1'b1, 16'd5, 16'd7, 1'b0);
        step("gate_idle", 1'b1, 1'b0, 'x, 'x, 1'bx);
        step("gate_idle", 1'b1, 1'b0, 'x, 'x, 1'bx);
        hard = {1'b0, 1'b0, 1'b0, 16'd12};
        check("const_hold12", {bus16.out_valid, bus16.c_out, bus16.overflow, bus16.out}, hard);
        step("gate_rst",  1'b0, 1'b1, 16'd9, 16'd9, 1'b0);
        step("resume",    1'b1, 1'b1, 16'd3, 16'd4, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            step("random", 1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        step("tail_idle", 1'b1, 1'b0, 16'd0, 16'd0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- Parameterised binary adder: two WIDTH-bit operands plus carry-in produce a WIDTH-bit sum and carry-out.
- Structurally a ripple-carry chain of single-bit full-adder stages.
- Outputs are registered on one clock with a valid strobe.
- Used as the reference/low-area adder in the arithmetic datapath, alongside the faster adder and multiplier blocks.

Parameters:
- WIDTH, 16, operand and sum width in bits; legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  qualifies a, b, c_in this cycle.
- a  input  WIDTH  operand A, unsigned (two's-complement interpretation only used for overflow).
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  out, c_out and overflow hold a new result.
- out  output  WIDTH  registered sum bits [WIDTH-1:0].
- c_out  output  1  registered carry out of bit WIDTH-1.
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- The interface uses one clock (clk). Reset (rst_n) is synchronous and active-low.
- Reset: on a rising clk edge with rst_n=0, the outputs are cleared: out=0, c_out=0, overflow=0, out_valid=0. Any input presented that cycle is discarded.
- Datapath structure:
  - Combinational chain of WIDTH full-adder stages.
  - Stage i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i].
  - c[0]=c_in; c_out = c[WIDTH].
  - Built with a generate loop of explicit full-adder logic, not a single vector "+" operator.
- Arithmetic: {c_out,out} = a + b + c_in, exact, computed at WIDTH+1 bits. The sum wraps modulo 2^WIDTH with the carry reported in c_out. overflow = c[WIDTH-1] ^ c[WIDTH].
- Latency: exactly 1 cycle.
  - On a rising edge with rst_n=1 and in_valid=1, out/c_out/overflow load the chain result for that edge's inputs, and out_valid becomes 1.
  - If in_valid=1 on consecutive cycles, a new result appears every cycle (throughput 1/cycle). There is no backpressure.
- Idle cycles: when in_valid=0 (rst_n=1), out_valid goes to 0 on that edge. out, c_out and overflow hold their previous values (no update, no clearing).
- Combinational path: inputs → register only. No combinational path from inputs to outputs.
- Reset mid-stream: a reset edge overrides in_valid=1. On the following edge with rst_n=1 and in_valid=1, normal operation resumes with 1-cycle latency.
- X on a, b or c_in while in_valid=0 must not propagate to the outputs.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with in_valid=1, a=b=16'hFFFF → out=0, c_out=0, overflow=0, out_valid=0 throughout.
- Directed sums (c_in=0), one per cycle with in_valid=1; each result appears one edge later with out_valid=1 and c_out=0:
  - 1+1 → 2
  - 1+10 → 11
  - 15+31 → 46
  - 128+1478 → 1606
  - 94+333 → 427
- Carry ripple/wrap:
  - a=16'hFFFF, b=16'h0001, c_in=0 → out=16'h0000, c_out=1, overflow=0.
  - a=16'hFFFF, b=0, c_in=1 → out=0, c_out=1. Exercises the full 16-stage ripple.
- Signed overflow:
  - a=16'h7FFF, b=16'h0001 → out=16'h8000, c_out=0, overflow=1.
  - a=16'h8000, b=16'h8000 → out=0, c_out=1, overflow=1.
- Valid gating: in_valid=1 (a=5, b=7), then in_valid=0 with a=b=X for 2 cycles.
  - Expected: out=12 with out_valid=1 for one cycle, then out_valid=0 while out stays 12.
  - Then assert rst_n=0 for one edge → out=0, out_valid=0.
- Random: 1000 random a, b, c_in back-to-back, compared against the (WIDTH+1)-bit sum a+b+c_in delayed one cycle.
  - Repeat the random run with WIDTH=8 to confirm parameterisation.
